// File: rtl/sram_arbiter_pkg.sv
// Shared widths and state encodings for the VRAM arbiter that fronts the
// board asynchronous SRAM.
package sram_arbiter_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD1   = 3'd1,
    RD2   = 3'd2,
    WR1   = 3'd3,
    WR2   = 3'd4,
    WHOLD = 3'd5
  } sram_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD1   = 3'd1;
  localparam logic [2:0] ST_RD2   = 3'd2;
  localparam logic [2:0] ST_WR1   = 3'd3;
  localparam logic [2:0] ST_WR2   = 3'd4;
  localparam logic [2:0] ST_WHOLD = 3'd5;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle: port A (GPU fetch, read-only) and port B
// (loader/debug, read/write with byte enables).
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  // Handshake: a requester raises req with addr (and we/wdata/be) stable and
  // holds them until ack pulses for one cycle; ack means the fields were
  // latched and may change from the next cycle. Each accepted read later
  // produces exactly one rvalid pulse with its rdata; writes produce none.
  logic                   a_req;
  logic [SRAM_ADDR_W-1:0] a_addr;
  logic                   a_ack;
  logic [SRAM_DATA_W-1:0] a_rdata;
  logic                   a_rvalid;

  logic                   b_req;
  logic                   b_we;
  logic [SRAM_ADDR_W-1:0] b_addr;
  logic [SRAM_DATA_W-1:0] b_wdata;
  logic [1:0]             b_be;
  logic                   b_ack;
  logic [SRAM_DATA_W-1:0] b_rdata;
  logic                   b_rvalid;

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata, b_be,
    input  a_ack, a_rdata, a_rvalid, b_ack, b_rdata, b_rvalid
  );

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, b_be,
    output a_ack, a_rdata, a_rvalid, b_ack, b_rdata, b_rvalid
  );

endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the asynchronous VRAM: A-priority with a starvation
// limit for B, two-cycle reads, three-cycle writes, all SRAM pins registered.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = SRAM_ADDR_W,
  parameter int DATA_W         = SRAM_DATA_W,
  parameter int B_STARVE_LIMIT = 8
) (
  input  logic              CLK_50,
  input  logic              RESET_N,
  sram_arbiter_if.slave     req_if,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output sram_state_t       dbg_state
);

  localparam logic [3:0] STARVE_MAX = 4'(B_STARVE_LIMIT);

  logic [2:0]        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              owner_b_q, owner_b_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        lane_n_q, lane_n_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic arb_slot, force_b, grant_a, grant_b, dq_drive;

  always_comb begin
    arb_slot = (state_q == ST_IDLE) || (state_q == ST_RD2) || (state_q == ST_WHOLD);
    force_b  = req_if.b_req && (starve_q == STARVE_MAX);
    grant_a  = arb_slot && req_if.a_req && !force_b;
    grant_b  = arb_slot && !grant_a && req_if.b_req;
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = req_if.b_req ? starve_q : 4'd0;
    owner_b_d = owner_b_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lane_n_d  = lane_n_q;
    a_ack_d   = grant_a;
    b_ack_d   = grant_b;

    case (state_q)
      ST_RD1:  state_d = ST_RD2;
      ST_WR1:  state_d = ST_WR2;
      ST_WR2:  state_d = ST_WHOLD;
      default: state_d = ST_IDLE;
    endcase

    if (grant_a) begin
      state_d   = ST_RD1;
      owner_b_d = 1'b0;
      addr_d    = req_if.a_addr;
      lane_n_d  = 2'b00;
      if (req_if.b_req && (starve_q != STARVE_MAX)) starve_d = starve_q + 4'd1;
    end else if (grant_b) begin
      state_d   = req_if.b_we ? ST_WR1 : ST_RD1;
      owner_b_d = 1'b1;
      addr_d    = req_if.b_addr;
      wdata_d   = req_if.b_wdata;
      lane_n_d  = ~req_if.b_be;
      starve_d  = 4'd0;
    end

    // Strobes are registered, so they are derived from the state being entered.
    ce_n_d = (state_d == ST_IDLE);
    oe_n_d = !((state_d == ST_RD1) || (state_d == ST_RD2));
    we_n_d = (state_d != ST_WR2);
    ub_n_d = ce_n_d | lane_n_d[1];
    lb_n_d = ce_n_d | lane_n_d[0];

    a_rvalid_d = (state_q == ST_RD2) && !owner_b_q;
    b_rvalid_d = (state_q == ST_RD2) && owner_b_q;
    a_rdata_d  = a_rvalid_d ? SRAM_DQ : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? SRAM_DQ : b_rdata_q;
  end

  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      starve_q   <= 4'd0;
      owner_b_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lane_n_q   <= 2'b11;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      owner_b_q  <= owner_b_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lane_n_q   <= lane_n_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      ub_n_q     <= ub_n_d;
      lb_n_q     <= lb_n_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign dq_drive = (state_q == ST_WR1) || (state_q == ST_WR2) || (state_q == ST_WHOLD);
  assign SRAM_DQ  = dq_drive ? wdata_q : {DATA_W{1'bz}};

  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_ADDR = addr_q;
  assign dbg_state = sram_state_t'(state_q);

  assign req_if.a_ack    = a_ack_q;
  assign req_if.b_ack    = b_ack_q;
  assign req_if.a_rvalid = a_rvalid_q;
  assign req_if.b_rvalid = b_rvalid_q;
  assign req_if.a_rdata  = a_rdata_q;
  assign req_if.b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: async SRAM model, reference memory with per-port
// expected-read queues, and directed scenarios with literal expectations.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_sampled = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_sampled <= !rst_n;
  end

  // ---------------- DUT ----------------
  sram_arbiter_if bus ();
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  sram_state_t dbg_state;

  sram_arbiter dut (
    .CLK_50    (clk),
    .RESET_N   (rst_n),
    .req_if    (bus),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq),
    .dbg_state (dbg_state)
  );

  // ---------------- SRAM model (256 words is enough for the bench) ----------------
  function automatic logic [15:0] init_word(input int i);
    if (i == 16'h10) return 16'h1234;
    if (i == 16'h20) return 16'hA5C3;
    if (i == 16'h30) return 16'h0F0F;
    return 16'h1000 + 16'(i);
  endfunction

  logic [15:0] mem [0:255];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [15:0] ref_mem [0:255];
  logic [15:0] a_exp_q[$];
  logic [15:0] b_exp_q[$];
  int          a_due_q[$];
  int          b_due_q[$];
  logic [15:0] a_hold = 16'h0;
  logic [15:0] b_hold = 16'h0;
  logic        a_exp_v, b_exp_v;
  logic        log_en = 1'b0;
  logic        grant_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_sampled) begin
      a_exp_q.delete(); b_exp_q.delete(); a_due_q.delete(); b_due_q.delete();
      a_hold = 16'h0;
      b_hold = 16'h0;
      chk("rst_a_ack", bus.a_ack, 0);
      chk("rst_b_ack", bus.b_ack, 0);
      chk("rst_a_rvalid", bus.a_rvalid, 0);
      chk("rst_b_rvalid", bus.b_rvalid, 0);
      chk("rst_a_rdata", bus.a_rdata, 0);
      chk("rst_b_rdata", bus.b_rdata, 0);
      chk("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
      chk("rst_addr", sram_addr, 0);
    end else begin
      chk("ack_exclusive", bus.a_ack & bus.b_ack, 0);
      if (log_en && bus.a_ack) grant_log.push_back(1'b0);
      if (log_en && bus.b_ack) grant_log.push_back(1'b1);
      a_exp_v = (a_due_q.size() > 0) && (a_due_q[0] == cyc);
      b_exp_v = (b_due_q.size() > 0) && (b_due_q[0] == cyc);
      chk("a_rvalid", bus.a_rvalid, a_exp_v);
      chk("b_rvalid", bus.b_rvalid, b_exp_v);
      if (a_exp_v) begin a_hold = a_exp_q.pop_front(); void'(a_due_q.pop_front()); end
      if (b_exp_v) begin b_hold = b_exp_q.pop_front(); void'(b_due_q.pop_front()); end
      chk("a_rdata", bus.a_rdata, a_hold);
      chk("b_rdata", bus.b_rdata, b_hold);
      if (!we_n) chk("we_with_ce_oe", {ce_n, oe_n}, 2'b01);
    end
  end

  // ---------------- drivers ----------------
  task automatic a_read(input logic [19:0] addr, output int ack_cyc);
    bit got = 1'b0;
    bus.a_req  = 1'b1;
    bus.a_addr = addr;
    ack_cyc    = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.a_ack) begin
        got = 1'b1;
        ack_cyc = cyc;
        a_exp_q.push_back(ref_mem[addr[7:0]]);
        a_due_q.push_back(cyc + 2);
      end
    end
    if (!got) chk("a_ack_timeout", 0, 1);
  endtask

  task automatic b_access(input logic we, input logic [19:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be, output int ack_cyc);
    bit got = 1'b0;
    bus.b_req   = 1'b1;
    bus.b_we    = we;
    bus.b_addr  = addr;
    bus.b_wdata = wdata;
    bus.b_be    = be;
    ack_cyc     = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.b_ack) begin
        got = 1'b1;
        ack_cyc = cyc;
        if (we) begin
          if (be[0]) ref_mem[addr[7:0]][7:0]  = wdata[7:0];
          if (be[1]) ref_mem[addr[7:0]][15:8] = wdata[15:8];
        end else begin
          b_exp_q.push_back(ref_mem[addr[7:0]]);
          b_due_q.push_back(cyc + 2);
        end
      end
    end
    if (!got) chk("b_ack_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  int t0, ac, ac_a, ac_b;
  int ack_c [4];
  logic [15:0] m30;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    bus.a_req = 1'b0; bus.a_addr = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0; bus.b_be = 2'b00;

    idle(3);
    rst_n = 1'b1;
    idle(2);

    // single A read: ack cycle 1, rvalid cycle 3
    t0 = cyc;
    a_read(20'h00010, ac);
    bus.a_req = 1'b0;
    chk("t1_ack_cycle", ac - t0, 1);
    chk("t1_oe_c1", {ce_n, oe_n}, 2'b00);
    @(negedge clk);
    chk("t1_oe_c2", oe_n, 0);
    @(negedge clk);
    chk("t1_rvalid", bus.a_rvalid, 1);
    chk("t1_rdata", bus.a_rdata, 16'h1234);
    chk("t1_rvalid_cycle", cyc - t0, 3);
    idle(2);

    // back-to-back A reads with no idle gaps
    t0 = cyc;
    for (int i = 0; i < 4; i++) a_read(20'(i), ack_c[i]);
    bus.a_req = 1'b0;
    for (int i = 0; i < 4; i++) chk("t2_ack_cycle", ack_c[i] - t0, 1 + 2 * i);
    idle(4);
    chk("t2_last_rdata", bus.a_rdata, 16'h1003);

    // B write, lower byte only
    b_access(1'b1, 20'h00020, 16'hBEEF, 2'b01, ac);
    bus.b_req = 1'b0;
    chk("t3_wr1", {ce_n, oe_n, we_n}, 3'b011);
    chk("t3_wr1_dq", sram_dq, 16'hBEEF);
    @(negedge clk);
    chk("t3_wr2", {we_n, ub_n, lb_n}, 3'b010);
    chk("t3_wr2_addr", sram_addr, 20'h00020);
    @(negedge clk);
    chk("t3_whold", {we_n, ub_n, lb_n}, 3'b110);
    chk("t3_whold_dq", sram_dq, 16'hBEEF);
    @(negedge clk);
    chk("t3_idle", {ce_n, we_n, ub_n, lb_n}, 4'b1111);
    chk("t3_mem", mem[8'h20], 16'hA5EF);
    idle(1);
    t0 = cyc;
    b_access(1'b0, 20'h00020, 16'h0000, 2'b11, ac);
    bus.b_req = 1'b0;
    chk("t3_b_only_ack", ac - t0, 1);
    idle(2);
    chk("t3_readback", bus.b_rdata, 16'hA5EF);
    idle(2);

    // simultaneous reads from IDLE: A first, B two cycles later
    t0 = cyc;
    fork
      begin a_read(20'h00001, ac_a); bus.a_req = 1'b0; end
      begin b_access(1'b0, 20'h00020, 16'h0000, 2'b11, ac_b); bus.b_req = 1'b0; end
    join
    chk("t6_a_first", ac_a - t0, 1);
    chk("t6_b_later", ac_b - ac_a, 2);
    idle(4);
    chk("t6_a_rdata", bus.a_rdata, 16'h1001);
    chk("t6_b_rdata", bus.b_rdata, 16'hA5EF);

    // both ports saturating: 8 A grants then 1 B grant, repeating
    grant_log.delete();
    log_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) a_read(20'h00040 + 20'(i), ac_a);
        bus.a_req = 1'b0;
      end
      begin
        for (int j = 0; j < 3; j++) b_access(1'b0, 20'h00080 + 20'(j), 16'h0, 2'b11, ac_b);
        bus.b_req = 1'b0;
      end
    join
    idle(1);
    log_en = 1'b0;
    chk("t4_grant_count", grant_log.size(), 27);
    for (int i = 0; i < grant_log.size() && i < 27; i++)
      chk("t4_grant_order", grant_log[i], (i % 9 == 8) ? 1 : 0);
    idle(4);

    // reset asserted during WR2
    b_access(1'b1, 20'h00030, 16'h5A5A, 2'b11, ac);
    bus.b_req = 1'b0;
    @(negedge clk);
    chk("t5_in_wr2", we_n, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_we_released", {ce_n, we_n}, 2'b11);
    chk("t5_state_idle", dbg_state, IDLE);
    rst_n = 1'b1;
    idle(2);
    m30 = mem[8'h30];
    chk("t5_mem_either", (m30 == 16'h0F0F) || (m30 == 16'h5A5A), 1);
    ref_mem[8'h30] = m30;
    a_read(20'h00030, ac);
    bus.a_req = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
